// File: rtl/dmem_pkg.sv
// Shared opcode values, FSM states, access sizes and request decode for the MEM-stage data responder.
// Holds no logic of its own; the helpers are pure combinational functions.
package dmem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic  legal;
        logic  store;
        logic  sext;
        size_t size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '{legal: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_WORD};
        case (op)
            OP_LW:   info.size = SZ_WORD;
            OP_LB:   begin info.size = SZ_BYTE; info.sext = 1'b1; end
            OP_LBU:  info.size = SZ_BYTE;
            OP_LH:   begin info.size = SZ_HALF; info.sext = 1'b1; end
            OP_LHU:  info.size = SZ_HALF;
            OP_SW:   begin info.size = SZ_WORD; info.store = 1'b1; end
            OP_SB:   begin info.size = SZ_BYTE; info.store = 1'b1; end
            OP_SH:   begin info.size = SZ_HALF; info.store = 1'b1; end
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

    // Unknown opcode, store/load direction disagreeing with req_we, or a misaligned half/word.
    function automatic logic access_err(input op_info_t info, input logic we, input logic [1:0] offs);
        logic misaligned;
        case (info.size)
            SZ_HALF: misaligned = offs[0];
            SZ_WORD: misaligned = |offs;
            default: misaligned = 1'b0;
        endcase
        return !info.legal || (info.store != we) || misaligned;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering: extracts/extends load data and builds the byte-enabled store merge word.
// Purely combinational, zero latency, no flow control.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_t       size,
    input  logic        sext,
    input  logic [1:0]  offs,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [31:0] lanes;
    logic [3:0]  be;

    always_comb begin
        shifted   = mem_word >> {offs, 3'b000};
        load_data = mem_word;
        lanes     = wdata;
        be        = 4'b1111;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
                lanes     = {4{wdata[7:0]}};
                be        = 4'b0001 << offs;
            end
            SZ_HALF: begin
                load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
                lanes     = {2{wdata[15:0]}};
                be        = offs[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        merged = mem_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = lanes[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: one access at a time, rsp_valid WAIT_CYCLES+1 cycles after acceptance.
// busy stalls the pipeline from the acceptance cycle through the wait states; it drops in DONE.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic        busy
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              cap_we;
    logic              cap_err;
    logic              cap_sext;
    size_t             cap_size;
    logic [ADDR_W+1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [31:0]       mem [2**ADDR_W];

    op_info_t          req_info;
    logic              req_err;
    logic              enter_done;
    logic              sel_we;
    logic              sel_err;
    logic              sel_sext;
    size_t             sel_size;
    logic [ADDR_W+1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [31:0]       rd_word;
    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    assign req_info   = decode_op(req_op);
    assign req_err    = access_err(req_info, req_we, req_addr[1:0]);
    assign busy       = (state == ST_IDLE && req_valid) || (state == ST_WAIT);
    assign enter_done = (state == ST_IDLE && req_valid && WAIT_CYCLES == 0) ||
                        (state == ST_WAIT && cnt == '0);

    // Live request in IDLE (needed when WAIT_CYCLES=0 jumps straight to DONE), captured copy otherwise.
    always_comb begin
        if (state == ST_IDLE) begin
            sel_we    = req_we;
            sel_err   = req_err;
            sel_sext  = req_info.sext;
            sel_size  = req_info.size;
            sel_addr  = req_addr[ADDR_W+1:0];
            sel_wdata = req_wdata;
        end else begin
            sel_we    = cap_we;
            sel_err   = cap_err;
            sel_sext  = cap_sext;
            sel_size  = cap_size;
            sel_addr  = cap_addr;
            sel_wdata = cap_wdata;
        end
    end

    assign rd_word = mem[sel_addr[ADDR_W+1:2]];

    dmem_lane_align u_align (
        .size      (sel_size),
        .sext      (sel_sext),
        .offs      (sel_addr[1:0]),
        .mem_word  (rd_word),
        .wdata     (sel_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_sext  <= 1'b0;
            cap_size  <= SZ_BYTE;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_rdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (enter_done) begin
                rsp_valid <= 1'b1;
                rsp_err   <= sel_err;
                rsp_rdata <= (sel_err || sel_we) ? '0 : load_data;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_err   <= req_err;
                        cap_sext  <= req_info.sext;
                        cap_size  <= req_info.size;
                        cap_addr  <= req_addr[ADDR_W+1:0];
                        cap_wdata <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) state <= ST_DONE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Array has no reset; a store aborted by reset never reaches DONE and so never writes.
    always_ff @(posedge clk) begin
        if (state == ST_DONE && cap_we && !cap_err) begin
            mem[cap_addr[ADDR_W+1:2]] <= merged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance against a byte-array model.
module tb_dmem_responder;

    localparam int ADDR_W    = 10;
    localparam int MEM_BYTES = 4 << ADDR_W;
    localparam int D2        = 0;
    localparam int D0        = 1;
    localparam logic [5:0] LW = 6'h23, LB = 6'h20, LBU = 6'h24, LH = 6'h21, LHU = 6'h25;
    localparam logic [5:0] SW = 6'h2B, SB = 6'h28, SH = 6'h29;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv2, rv0, req_we;
    logic [5:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rdata2, rdata0;
    logic        v2, v0, e2, e0, busy2, busy0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  mem_m [2][MEM_BYTES];
    logic [31:0] got_rd, exp_rd;
    logic        got_er, exp_er;
    int          got_lat, got_busy, got_acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .req_valid(rv2), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_rdata(rdata2), .rsp_valid(v2),
        .rsp_err(e2), .busy(busy2)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_rdata(rdata0), .rsp_valid(v0),
        .rsp_err(e0), .busy(busy0)
    );

    // Byte-addressed reference: size/sign from the opcode table, address taken modulo the array size.
    function automatic void model(input int which, input logic we, input logic [5:0] op,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic er);
        int nbytes;
        bit sgn;
        bit st;
        int base;
        nbytes = 0; sgn = 0; st = 0;
        case (op)
            6'h23: nbytes = 4;
            6'h20: begin nbytes = 1; sgn = 1; end
            6'h24: nbytes = 1;
            6'h21: begin nbytes = 2; sgn = 1; end
            6'h25: nbytes = 2;
            6'h2B: begin nbytes = 4; st = 1; end
            6'h28: begin nbytes = 1; st = 1; end
            6'h29: begin nbytes = 2; st = 1; end
            default: nbytes = 0;
        endcase
        base = int'(addr % 32'(MEM_BYTES));
        rd = '0;
        er = (nbytes == 0);
        if (!er) er = (st != bit'(we)) || (base % nbytes != 0);
        if (er) return;
        if (st) begin
            for (int i = 0; i < nbytes; i++) mem_m[which][base + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < nbytes; i++) rd[8*i +: 8] = mem_m[which][base + i];
            if (sgn) for (int i = 8 * nbytes; i < 32; i++) rd[i] = rd[8*nbytes - 1];
        end
    endfunction

    // Holds the request until rsp_valid, scribbling the request fields after acceptance.
    task automatic xact(input int which, input logic we, input logic [5:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int c;
        bit done;
        @(negedge clk);
        req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        if (which == D2) rv2 = 1'b1; else rv0 = 1'b1;
        got_acc = cyc; got_busy = 0; got_lat = -1; got_rd = '0; got_er = 1'b0;
        c = 0; done = 0;
        #1;
        while (!done && c < 16) begin
            if ((which == D2) ? busy2 : busy0) got_busy++;
            if ((which == D2) ? v2 : v0) begin
                done    = 1;
                got_lat = c;
                got_rd  = (which == D2) ? rdata2 : rdata0;
                got_er  = (which == D2) ? e2 : e0;
            end else begin
                @(negedge clk);
                c++;
                req_op = 6'($urandom); req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
                #1;
            end
        end
        rv2 = 1'b0; rv0 = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout dut%0d op=%h addr=%h: no rsp_valid within %0d cycles", which, op, addr, c);
        end
        model(which, we, op, addr, wdata, exp_rd, exp_er);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rdata2, v2, e2, busy2} !== 35'h0) begin
            errors++; $display("FAIL reset_dut2: rdata=%h valid=%b err=%b busy=%b, want all 0", rdata2, v2, e2, busy2);
        end
        checks++;
        if ({rdata0, v0, e0, busy0} !== 35'h0) begin
            errors++; $display("FAIL reset_dut0: rdata=%h valid=%b err=%b busy=%b, want all 0", rdata0, v0, e0, busy0);
        end
        reset = 1'b0;
    endtask

    task automatic test_word();
        xact(D2, 1'b1, SW, 32'h10, 32'hDEADBEEF);
        checks++;
        if (got_busy !== 3 || got_lat !== 3) begin
            errors++; $display("FAIL sw_timing: busy=%0d lat=%0d, want 3 and 3", got_busy, got_lat);
        end
        checks++;
        if (got_rd !== 32'h0 || got_er !== 1'b0) begin
            errors++; $display("FAIL sw_rsp: rdata=%h err=%b, want 0 and 0", got_rd, got_er);
        end
        xact(D2, 1'b0, LW, 32'h10, 32'h0);
        checks++;
        if (got_busy !== 3 || got_lat !== 3) begin
            errors++; $display("FAIL lw_timing: busy=%0d lat=%0d, want 3 and 3", got_busy, got_lat);
        end
        checks++;
        if (got_rd !== 32'hDEADBEEF || got_er !== 1'b0) begin
            errors++; $display("FAIL lw_data: rdata=%h err=%b, want deadbeef and 0", got_rd, got_er);
        end
    endtask

    task automatic test_byte();
        xact(D2, 1'b1, SW, 32'h10, 32'h0);
        xact(D2, 1'b1, SB, 32'h11, 32'h80);
        xact(D2, 1'b0, LB, 32'h11, 32'h0);
        checks++;
        if (got_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h want ffffff80", got_rd); end
        xact(D2, 1'b0, LBU, 32'h11, 32'h0);
        checks++;
        if (got_rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h want 00000080", got_rd); end
        xact(D2, 1'b0, LW, 32'h10, 32'h0);
        checks++;
        if (got_rd !== 32'h00008000) begin errors++; $display("FAIL sb_merge: got %h want 00008000", got_rd); end
    endtask

    task automatic test_half();
        xact(D2, 1'b1, SW, 32'h20, 32'h0);
        xact(D2, 1'b1, SH, 32'h22, 32'h1234);
        xact(D2, 1'b0, LH, 32'h22, 32'h0);
        checks++;
        if (got_rd !== 32'h00001234) begin errors++; $display("FAIL lh_upper: got %h want 00001234", got_rd); end
        xact(D2, 1'b0, LHU, 32'h22, 32'h0);
        checks++;
        if (got_rd !== 32'h00001234) begin errors++; $display("FAIL lhu_upper: got %h want 00001234", got_rd); end
        xact(D2, 1'b0, LW, 32'h20, 32'h0);
        checks++;
        if (got_rd !== 32'h12340000) begin errors++; $display("FAIL sh_merge: got %h want 12340000", got_rd); end
        xact(D2, 1'b1, SH, 32'h20, 32'hABCD8001);
        xact(D2, 1'b0, LH, 32'h20, 32'h0);
        checks++;
        if (got_rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sext: got %h want ffff8001", got_rd); end
    endtask

    task automatic test_errors();
        logic [5:0]  ops   [6] = '{LW, LH, SB, 6'h3F, SW, SB};
        logic        wes   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] addrs [6] = '{32'h13, 32'h21, 32'h10, 32'h10, 32'h12, 32'h1};
        for (int i = 0; i < 6; i++) begin
            // The final sb is legal but targets another lane; it exercises err=0 in the same sweep.
            xact(D2, wes[i], ops[i], addrs[i], 32'hFFFFFFFF);
            checks++;
            if (got_er !== (i < 5) || got_rd !== 32'h0 || got_lat !== 3) begin
                errors++;
                $display("FAIL err_case%0d: err=%b rdata=%h lat=%0d, want err=%b rdata=0 lat=3", i, got_er, got_rd, got_lat, (i < 5));
            end
        end
        xact(D2, 1'b0, LW, 32'h10, 32'h0);
        checks++;
        if (got_rd !== 32'h00008000) begin errors++; $display("FAIL err_no_write: got %h want 00008000", got_rd); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        xact(D2, 1'b1, SW, 32'h30, 32'h55AA55AA);
        @(negedge clk);
        req_we = 1'b1; req_op = SW; req_addr = 32'h30; req_wdata = 32'h11111111; rv2 = 1'b1;
        @(negedge clk);
        checks++;
        if (busy2 !== 1'b1) begin errors++; $display("FAIL mid_wait_busy: got %b want 1", busy2); end
        reset = 1'b1; rv2 = 1'b0;
        #1;
        checks++;
        if (busy2 !== 1'b0 || v2 !== 1'b0) begin
            errors++; $display("FAIL mid_reset_now: busy=%b valid=%b, want 0 0", busy2, v2);
        end
        seen = 0;
        repeat (2) begin @(negedge clk); if (v2 !== 1'b0) seen = 1; end
        reset = 1'b0;
        repeat (4) begin @(negedge clk); if (v2 !== 1'b0) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_reset_no_rsp: rsp_valid seen=1 want 0"); end
        xact(D2, 1'b0, LW, 32'h30, 32'h0);
        checks++;
        if (got_rd !== 32'h55AA55AA) begin errors++; $display("FAIL mid_reset_old: got %h want 55aa55aa", got_rd); end
    endtask

    task automatic test_back_to_back();
        int a;
        xact(D2, 1'b0, LW, 32'h10, 32'h0);
        a = got_acc;
        xact(D2, 1'b0, LW, 32'h20, 32'h0);
        checks++;
        if (got_acc - a !== 4 || got_rd !== 32'h12348001) begin
            errors++; $display("FAIL b2b_wait2: spacing=%0d rdata=%h, want 4 and 12348001", got_acc - a, got_rd);
        end
    endtask

    task automatic test_wait0();
        int a;
        xact(D0, 1'b1, SW, 32'h10, 32'hCAFEF00D);
        xact(D0, 1'b1, SW, 32'h14, 32'h0BADBEEF);
        xact(D0, 1'b0, LW, 32'h10, 32'h0);
        a = got_acc;
        checks++;
        if (got_lat !== 1 || got_busy !== 1 || got_rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL w0_first: lat=%0d busy=%0d rdata=%h, want 1 1 cafef00d", got_lat, got_busy, got_rd);
        end
        xact(D0, 1'b0, LW, 32'h14, 32'h0);
        checks++;
        if (got_lat !== 1 || got_acc - a !== 2 || got_rd !== 32'h0BADBEEF) begin
            errors++; $display("FAIL w0_second: lat=%0d spacing=%0d rdata=%h, want 1 2 0badbeef", got_lat, got_acc - a, got_rd);
        end
        xact(D0, 1'b0, LW, 32'h1010, 32'h0);
        checks++;
        if (got_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL w0_alias: got %h want cafef00d", got_rd); end
    endtask

    task automatic test_random();
        logic [5:0] ops [8] = '{LW, LB, LBU, LH, LHU, SW, SB, SH};
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 8; k++) xact(w, 1'b1, SW, 32'h200 + 32'(4 * k), $urandom);
            for (int n = 0; n < 40; n++) begin
                int          r;
                logic [5:0]  op;
                logic        we;
                logic [31:0] a;
                r  = int'($urandom_range(0, 9));
                op = (r < 8) ? ops[r] : 6'($urandom);
                we = (r >= 5 && r < 8);
                if ($urandom_range(0, 7) == 0) we = ~we;
                a  = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)) + (32'($urandom_range(0, 15)) << 12);
                xact(w, we, op, a, $urandom);
                checks++;
                if (got_rd !== exp_rd || got_er !== exp_er) begin
                    errors++;
                    $display("FAIL rand_dut%0d op=%h we=%b addr=%h: rdata=%h err=%b, want %h %b", w, op, we, a, got_rd, got_er, exp_rd, exp_er);
                end
                checks++;
                if (got_lat !== ((w == D2) ? 3 : 1)) begin
                    errors++; $display("FAIL rand_lat_dut%0d: got %0d want %0d", w, got_lat, (w == D2) ? 3 : 1);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; rv2 = 1'b0; rv0 = 1'b0; req_we = 1'b0;
        req_op = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_wait0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
